change_dispenser: RTL and testbench

//   Downstream stage of the change-computation logic. Latches a FirstCoin/SecondCoin pair on a

---
 rtl/change_dispenser.sv | 154 +++++++++++++++
 tb/tb_change_dispenser.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: latches a coin pair on start, ejects the coins one at a
// time over valid/ready, owns the coin inventory, and detects ejector jams.
module change_dispenser #(
   parameter logic [1:0] INIT_P      = 2'd3,
   parameter logic [1:0] INIT_T      = 2'd3,
   parameter logic [1:0] INIT_C      = 2'd3,
   parameter int unsigned STALL_LIMIT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] first_coin,
   input  logic [2:0] second_coin,
   input  logic       not_enough,
   input  logic       reload,
   input  logic [1:0] reload_p,
   input  logic [1:0] reload_t,
   input  logic [1:0] reload_c,
   input  logic       clear_jam,
   input  logic       coin_ready,
   output logic       coin_valid,
   output logic [2:0] coin_out,
   output logic [1:0] pentagons,
   output logic [1:0] triangles,
   output logic [1:0] circles,
   output logic       busy,
   output logic       done,
   output logic       reject,
   output logic       jam
);

   typedef enum logic [2:0] {IDLE, FIRST, SECOND, DONE, JAM} state_t;

   localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

   state_t     state_q, state_d;
   logic [2:0] first_q, first_d, second_q, second_d;
   logic [1:0] p_d, t_d, c_d;
   logic [7:0] stall_q, stall_d;
   logic       reject_d;
   logic       hs;
   logic [2:0] cur_code;
   logic [1:0] need_p, need_t, need_c;
   logic       codes_ok, stock_ok;

   function automatic logic code_valid(input logic [2:0] code);
      return (code == 3'd0) || (code == 3'd1) || (code == 3'd3) || (code == 3'd5);
   endfunction

   // coin_valid is only ever high in FIRST/SECOND, so it doubles as the handshake qualifier
   assign hs       = coin_valid && coin_ready;
   assign cur_code = (state_q == SECOND) ? second_q : first_q;

   // Per-type demand of the presented pair, checked against stock before acceptance
   always_comb begin
      need_p   = {1'b0, first_coin == 3'd5} + {1'b0, second_coin == 3'd5};
      need_t   = {1'b0, first_coin == 3'd3} + {1'b0, second_coin == 3'd3};
      need_c   = {1'b0, first_coin == 3'd1} + {1'b0, second_coin == 3'd1};
      codes_ok = code_valid(first_coin) && code_valid(second_coin);
      stock_ok = (pentagons >= need_p) && (triangles >= need_t) && (circles >= need_c);
   end

   // Next-state, inventory and latched-pair logic
   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      second_d = second_q;
      p_d      = pentagons;
      t_d      = triangles;
      c_d      = circles;
      stall_d  = stall_q;
      reject_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (reload) begin
               // reload takes priority; a same-cycle start is silently dropped
               p_d = reload_p;
               t_d = reload_t;
               c_d = reload_c;
            end else if (start) begin
               if (not_enough || !codes_ok || !stock_ok) begin
                  reject_d = 1'b1;
               end else begin
                  first_d  = first_coin;
                  second_d = second_coin;
                  stall_d  = '0;
                  if (first_coin != 3'd0)       state_d = FIRST;
                  else if (second_coin != 3'd0) state_d = SECOND;
                  else                          state_d = DONE;
               end
            end
         end
         FIRST, SECOND: begin
            if (hs) begin
               stall_d = '0;
               case (cur_code)
                  3'd5:    if (pentagons != 2'd0) p_d = pentagons - 2'd1;
                  3'd3:    if (triangles != 2'd0) t_d = triangles - 2'd1;
                  3'd1:    if (circles   != 2'd0) c_d = circles   - 2'd1;
                  default: ;
               endcase
               if (state_q == FIRST && second_q != 3'd0) state_d = SECOND;
               else                                       state_d = DONE;
            end else begin
               stall_d = stall_q + 8'd1;
               if (stall_q == STALL_LAST) state_d = JAM;
            end
         end
         DONE: state_d = IDLE;
         JAM: begin
            if (clear_jam) begin
               state_d = IDLE;
               stall_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, inventory and registered outputs (all derived from next state)
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         first_q    <= '0;
         second_q   <= '0;
         stall_q    <= '0;
         pentagons  <= INIT_P;
         triangles  <= INIT_T;
         circles    <= INIT_C;
         coin_valid <= 1'b0;
         coin_out   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         reject     <= 1'b0;
         jam        <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         second_q   <= second_d;
         stall_q    <= stall_d;
         pentagons  <= p_d;
         triangles  <= t_d;
         circles    <= c_d;
         coin_valid <= (state_d == FIRST) || (state_d == SECOND);
         coin_out   <= (state_d == FIRST)  ? first_d  :
                       (state_d == SECOND) ? second_d : 3'd0;
         busy       <= (state_d != IDLE);
         done       <= (state_d == DONE);
         reject     <= reject_d;
         jam        <= (state_d == JAM);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: expected coins go into a
// scoreboard queue when a pair is started and are checked at each handshake.
module tb_change_dispenser;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] first_coin, second_coin;
   logic       not_enough, reload;
   logic [1:0] reload_p, reload_t, reload_c;
   logic       clear_jam, coin_ready;
   logic       coin_valid;
   logic [2:0] coin_out;
   logic [1:0] pentagons, triangles, circles;
   logic       busy, done, reject, jam;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [2:0] sb_q[$];
   logic [2:0] exp_coin;

   change_dispenser #(.INIT_P(2'd3), .INIT_T(2'd3), .INIT_C(2'd3), .STALL_LIMIT(15)) dut (
      .clock(clock), .reset(reset), .start(start), .first_coin(first_coin),
      .second_coin(second_coin), .not_enough(not_enough), .reload(reload),
      .reload_p(reload_p), .reload_t(reload_t), .reload_c(reload_c),
      .clear_jam(clear_jam), .coin_ready(coin_ready), .coin_valid(coin_valid),
      .coin_out(coin_out), .pentagons(pentagons), .triangles(triangles),
      .circles(circles), .busy(busy), .done(done), .reject(reject), .jam(jam)
   );

   always #5 clock = ~clock;

   // One clock: at the negedge, score any handshake about to happen; return #1 after posedge
   task automatic tick();
      @(negedge clock);
      if (!reset && coin_valid && coin_ready) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_coin: got %0d, expected no coin", coin_out);
         end else begin
            exp_coin = sb_q.pop_front();
            if (coin_out !== exp_coin) begin
               tests_failed++;
               $display("FAIL sb_coin: got %0d, expected %0d", coin_out, exp_coin);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_inv(input string name, input logic [1:0] p, input logic [1:0] t, input logic [1:0] c);
      tests_run++;
      if ({pentagons, triangles, circles} !== {p, t, c}) begin
         tests_failed++;
         $display("FAIL %s: got inventory %0d/%0d/%0d, expected %0d/%0d/%0d",
                  name, pentagons, triangles, circles, p, t, c);
      end
   endtask

   task automatic drive_start(input logic [2:0] f, input logic [2:0] s);
      start = 1'b1; first_coin = f; second_coin = s;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; first_coin = 0; second_coin = 0; not_enough = 0;
      reload = 0; reload_p = 0; reload_t = 0; reload_c = 0; clear_jam = 0; coin_ready = 0;
      tick(); tick();
      tests_run++;
      if ({coin_valid, coin_out, busy, done, reject, jam} !== 8'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b, expected 0", {coin_valid, coin_out, busy, done, reject, jam});
      end
      chk_inv("reset_inventory", 2'd3, 2'd3, 2'd3);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      coin_ready = 1'b1;
      drive_start(3'd5, 3'd3); sb_q.push_back(3'd5); sb_q.push_back(3'd3);
      tick();
      chk("basic_valid_t1", {7'd0, coin_valid}, 8'd1);
      chk("basic_coin_t1", {5'd0, coin_out}, 8'd5);
      drive_start(3'd1, 3'd1);        // start while busy must be ignored
      tick();
      chk("basic_coin_t2", {5'd0, coin_out}, 8'd3);
      chk("basic_reject_busy", {7'd0, reject}, 8'd0);
      start = 1'b0;
      tick();
      chk("basic_done_t3", {6'd0, done, coin_valid}, 8'b10);
      tick();
      chk("basic_idle", {6'd0, done, busy}, 8'b00);
      chk_inv("basic_inventory", 2'd2, 2'd2, 2'd3);
   endtask

   task automatic test_stall_ready();
      coin_ready = 1'b0;
      drive_start(3'd5, 3'd1); sb_q.push_back(3'd5); sb_q.push_back(3'd1);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_hold", {coin_valid, coin_out, 2'd0, pentagons}, {1'b1, 3'd5, 2'd0, 2'd2});
      end
      coin_ready = 1'b1;
      tick();
      chk("stall_after_hs", {coin_out, 3'd0, pentagons}, {3'd1, 3'd0, 2'd1});
      tick();
      chk("stall_done", {7'd0, done}, 8'd1);
      tick();
      chk_inv("stall_inventory", 2'd1, 2'd2, 2'd2);
   endtask

   task automatic test_reject();
      drive_start(3'd5, 3'd5);        // needs two pentagons, only one left
      tick();
      start = 1'b0;
      chk("rej_inv_pulse", {6'd0, reject, busy}, 8'b10);
      chk_inv("rej_inv_inventory", 2'd1, 2'd2, 2'd2);
      tick();
      chk("rej_inv_pulse_end", {7'd0, reject}, 8'd0);
      not_enough = 1'b1; drive_start(3'd1, 3'd0);
      tick();
      start = 1'b0; not_enough = 1'b0;
      chk("rej_not_enough", {6'd0, reject, coin_valid}, 8'b10);
      drive_start(3'd2, 3'd0);        // illegal coin code
      tick();
      start = 1'b0;
      chk("rej_bad_code", {6'd0, reject, busy}, 8'b10);
      drive_start(3'd0, 3'd0);
      tick();
      start = 1'b0;
      chk("empty_pair_done", {5'd0, done, coin_valid, reject}, 8'b100);
      tick();
      chk("empty_pair_idle", {6'd0, done, busy}, 8'b00);
      chk_inv("empty_pair_inventory", 2'd1, 2'd2, 2'd2);
   endtask

   task automatic test_jam();
      coin_ready = 1'b0;
      drive_start(3'd3, 3'd0);        // not pushed: this coin must never be ejected
      tick();
      start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      chk("jam_before_limit", {6'd0, jam, coin_valid}, 8'b01);
      tick();
      chk("jam_at_limit", {5'd0, jam, coin_valid, busy}, 8'b101);
      chk_inv("jam_inventory", 2'd1, 2'd2, 2'd2);
      drive_start(3'd0, 3'd0);
      tick();
      start = 1'b0;
      chk("jam_holds", {6'd0, jam, reject}, 8'b10);
      clear_jam = 1'b1;
      tick();
      clear_jam = 1'b0;
      chk("jam_cleared", {5'd0, jam, busy, done}, 8'b000);
   endtask

   task automatic test_reload();
      reload = 1'b1; reload_p = 2'd1; reload_t = 2'd0; reload_c = 2'd2;
      drive_start(3'd1, 3'd0);
      tick();
      reload = 1'b0; start = 1'b0;
      chk_inv("reload_counts", 2'd1, 2'd0, 2'd2);
      chk("reload_no_reject", {6'd0, reject, busy}, 8'b00);
      coin_ready = 1'b0;
      drive_start(3'd1, 3'd0); sb_q.push_back(3'd1);
      tick();
      start = 1'b0;
      reload = 1'b1; reload_p = 2'd3; reload_t = 2'd3; reload_c = 2'd3;
      tick();
      reload = 1'b0;
      chk_inv("reload_busy_ignored", 2'd1, 2'd0, 2'd2);
      coin_ready = 1'b1;
      tick();
      chk("reload_tx_done", {7'd0, done}, 8'd1);
      tick();
      chk_inv("reload_tx_inventory", 2'd1, 2'd0, 2'd1);
   endtask

   task automatic test_reset_mid();
      reload = 1'b1; reload_p = 2'd3; reload_t = 2'd3; reload_c = 2'd3;
      tick();
      reload = 1'b0;
      coin_ready = 1'b1;
      drive_start(3'd5, 3'd3); sb_q.push_back(3'd5); sb_q.push_back(3'd3);
      tick();
      start = 1'b0;
      tick();
      chk("mid_in_second", {coin_out, 3'd0, pentagons}, {3'd3, 3'd0, 2'd2});
      coin_ready = 1'b0;
      reset = 1'b1;
      tick();
      tests_run++;
      if ({coin_valid, coin_out, busy, done, reject, jam} !== 8'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got %b, expected 0", {coin_valid, coin_out, busy, done, reject, jam});
      end
      chk_inv("mid_reset_inventory", 2'd3, 2'd3, 2'd3);
      reset = 1'b0;
      void'(sb_q.pop_back());         // the abandoned second coin
      tick();
      chk("mid_reset_idle", {6'd0, busy, coin_valid}, 8'b00);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_ready();
      test_reject();
      test_jam();
      test_reload();
      test_reset_mid();
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_leftover: got %0d pending coins, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
